// File: rtl/dm_dmi_arb_pkg.sv
// Constants and helpers shared by the DMI initiator arbiter and its routing FIFO.
package dm_dmi_arb_pkg;

  localparam int unsigned DmiArbMaxInit = 8;
  localparam int unsigned LockWdLimit   = 16;

  // Round-robin successor of an initiator ID, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned id, input int unsigned n);
    return (id + 1 >= n) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/dm_pkg.sv
// Shared debug-module DMI types: request/response structs and DTM operation codes.
package dm;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_e;

  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

endpackage

// File: rtl/dm_dmi_arb_fifo.sv
// In-order FIFO of initiator IDs, one entry per accepted-but-unanswered DMI request.
module dm_dmi_arb_fifo #(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           cnt_q;
  logic                    push, pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign push    = push_i & ~full_o;
  assign pop     = pop_i & ~empty_o;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/dm_dmi_arb.sv
// Round-robin arbiter sharing one DMI port between NrInit initiators, routing responses back in order.
// Optional initiator lock with idle watchdog is enabled by defining DM_DMI_ARB_LOCK_EN.
module dm_dmi_arb
  import dm_dmi_arb_pkg::*;
#(
  parameter int unsigned NrInit         = 2,
  parameter int unsigned MaxOutstanding = 2,
  localparam int unsigned IdW           = (NrInit > 1) ? $clog2(NrInit) : 1,
  localparam int unsigned CW            = $clog2(MaxOutstanding + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
`ifdef DM_DMI_ARB_LOCK_EN
  input  logic [NrInit-1:0]             init_lock_i,
`endif
  input  logic [NrInit-1:0]             init_req_valid_i,
  output logic [NrInit-1:0]             init_req_ready_o,
  input  dm::dmi_req_t [NrInit-1:0]     init_req_i,
  output logic [NrInit-1:0]             init_resp_valid_o,
  input  logic [NrInit-1:0]             init_resp_ready_i,
  output dm::dmi_resp_t [NrInit-1:0]    init_resp_o,
  output logic                          dmi_req_valid_o,
  input  logic                          dmi_req_ready_i,
  output dm::dmi_req_t                  dmi_req_o,
  input  logic                          dmi_resp_valid_i,
  output logic                          dmi_resp_ready_o,
  input  dm::dmi_resp_t                 dmi_resp_i,
  output logic                          unexp_resp_o,
  output logic [CW-1:0]                 outstanding_o
);

  logic [IdW-1:0]    ptr_q, ptr_d, start, gnt_id, head_id;
  logic [NrInit-1:0] eff_valid;
  logic              gnt_found, gnt_vld, req_hs, fifo_full, fifo_empty, fifo_pop;

`ifdef DM_DMI_ARB_LOCK_EN
  logic [IdW-1:0] owner_q;
  logic           owner_vld_q, wd_exp_q, lock_act;
  logic [3:0]     wd_cnt_q;

  assign lock_act = owner_vld_q & init_lock_i[owner_q] & ~wd_exp_q;

  always_comb begin
    eff_valid = init_req_valid_i;
    start     = ptr_q;
    if (lock_act) begin
      eff_valid          = '0;
      eff_valid[owner_q] = init_req_valid_i[owner_q];
      start              = owner_q;
    end
  end

  // Owner tracking; the watchdog voids the lock after LockWdLimit idle cycles of the owner.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      wd_cnt_q    <= '0;
      wd_exp_q    <= 1'b0;
    end else if (req_hs) begin
      owner_q     <= gnt_id;
      owner_vld_q <= 1'b1;
      wd_cnt_q    <= '0;
      wd_exp_q    <= 1'b0;
    end else if (owner_vld_q && !init_lock_i[owner_q]) begin
      owner_vld_q <= 1'b0;
    end else if (owner_vld_q && !init_req_valid_i[owner_q]) begin
      if (wd_cnt_q == 4'(LockWdLimit - 1)) wd_exp_q <= 1'b1;
      else                                 wd_cnt_q <= wd_cnt_q + 4'd1;
    end else if (owner_vld_q) begin
      wd_cnt_q <= '0;
    end
  end
`else
  assign eff_valid = init_req_valid_i;
  assign start     = ptr_q;
`endif

  // First valid initiator at or after the start pointer, wrapping at NrInit.
  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int i = 0; i < int'(NrInit); i++) begin
      idx = int'(start) + i;
      if (idx >= int'(NrInit)) idx = idx - int'(NrInit);
      if (!gnt_found && eff_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = IdW'(idx);
      end
    end
  end

  assign gnt_vld         = gnt_found & ~fifo_full & ~clear_i;
  assign req_hs          = gnt_vld & dmi_req_ready_i;
  assign dmi_req_valid_o = gnt_vld;
  assign dmi_req_o       = gnt_vld ? init_req_i[gnt_id] : '0;

  always_comb begin
    init_req_ready_o = '0;
    if (gnt_vld) init_req_ready_o[gnt_id] = dmi_req_ready_i;
  end

  assign ptr_d = IdW'(rr_next(int'(gnt_id), NrInit));

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) ptr_q <= '0;
    else if (req_hs)      ptr_q <= ptr_d;
  end

  dm_dmi_arb_fifo #(
    .W     (IdW),
    .DEPTH (MaxOutstanding)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .push_i  (req_hs),
    .data_i  (gnt_id),
    .pop_i   (fifo_pop),
    .data_o  (head_id),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding_o)
  );

  assign init_resp_o = {NrInit{dmi_resp_i}};

  // Responses with nowhere to go (clear cycle or empty FIFO) are accepted and dropped.
  always_comb begin
    init_resp_valid_o = '0;
    dmi_resp_ready_o  = 1'b0;
    unexp_resp_o      = 1'b0;
    fifo_pop          = 1'b0;
    if (clear_i) begin
      dmi_resp_ready_o = 1'b1;
    end else if (!fifo_empty) begin
      init_resp_valid_o[head_id] = dmi_resp_valid_i;
      dmi_resp_ready_o           = init_resp_ready_i[head_id];
      fifo_pop                   = dmi_resp_valid_i & init_resp_ready_i[head_id];
    end else begin
      dmi_resp_ready_o = dmi_resp_valid_i;
      unexp_resp_o     = dmi_resp_valid_i;
    end
  end

endmodule

// File: tb/tb_dm_dmi_arb.sv
// Directed bench for dm_dmi_arb with two initiators and a two-deep routing FIFO.
module tb_dm_dmi_arb;
  import dm::*;

  logic            clk, rst, clr;
  logic [1:0]      rv, rr_o, resp_v_o, resp_rdy;
  dmi_req_t [1:0]  req;
  dmi_resp_t [1:0] resp_o;
  logic            dv_o, drdy, drv, drr_o, unexp;
  dmi_req_t        dreq_o;
  dmi_resp_t       dresp;
  logic [1:0]      outs;
  int              checks = 0, fails = 0;

  dm_dmi_arb #(.NrInit(2), .MaxOutstanding(2)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clr),
`ifdef DM_DMI_ARB_LOCK_EN
    .init_lock_i(2'b00),
`endif
    .init_req_valid_i(rv), .init_req_ready_o(rr_o), .init_req_i(req),
    .init_resp_valid_o(resp_v_o), .init_resp_ready_i(resp_rdy), .init_resp_o(resp_o),
    .dmi_req_valid_o(dv_o), .dmi_req_ready_i(drdy), .dmi_req_o(dreq_o),
    .dmi_resp_valid_i(drv), .dmi_resp_ready_o(drr_o), .dmi_resp_i(dresp),
    .unexp_resp_o(unexp), .outstanding_o(outs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    clr = 0; rv = 0; resp_rdy = 2'b11; drdy = 1; drv = 0; dresp = '0;
    req[0] = '{addr: 7'h20, op: DTM_READ, data: 32'h0};
    req[1] = '{addr: 7'h21, op: DTM_READ, data: 32'h0};
  endtask

  task automatic do_reset();
    idle_inputs(); rst = 1; tick(); rst = 0; #1;
  endtask

  task automatic test_reset();
    idle_inputs(); resp_rdy = 0; drdy = 0; rst = 1; tick(); #1;
    checks++; if (outs !== 2'd0) begin fails++; $display("FAIL reset_outstanding got=%0d exp=0", outs); end
    checks++; if ({dv_o, rr_o, resp_v_o, drr_o, unexp} !== 7'b0) begin fails++; $display("FAIL reset_outputs got=%b exp=0", {dv_o, rr_o, resp_v_o, drr_o, unexp}); end
    rst = 0;
  endtask

  task automatic test_single();
    do_reset();
    rv = 2'b01; req[0] = '{addr: 7'h11, op: DTM_READ, data: 32'h0}; #1;
    checks++; if (dv_o !== 1'b1 || dreq_o.addr !== 7'h11) begin fails++; $display("FAIL single_req got=%b/%h exp=1/11", dv_o, dreq_o.addr); end
    checks++; if (rr_o !== 2'b01) begin fails++; $display("FAIL single_ready got=%b exp=01", rr_o); end
    tick(); rv = 0; #1;
    checks++; if (outs !== 2'd1) begin fails++; $display("FAIL single_outs1 got=%0d exp=1", outs); end
    drv = 1; dresp = '{data: 32'h0000_0C82, resp: 2'b00}; #1;
    checks++; if (resp_v_o !== 2'b01 || resp_o[0].data !== 32'h0000_0C82) begin fails++; $display("FAIL single_resp got=%b/%h exp=01/00000c82", resp_v_o, resp_o[0].data); end
    checks++; if (drr_o !== 1'b1) begin fails++; $display("FAIL single_resp_ready got=%b exp=1", drr_o); end
    tick(); drv = 0; #1;
    checks++; if (outs !== 2'd0) begin fails++; $display("FAIL single_outs0 got=%0d exp=0", outs); end
  endtask

  task automatic test_contention();
    int g, prev;
    do_reset();
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      g = k % 2;
      rv = (k < 4) ? 2'b11 : 2'b00;
      drv = (k > 0);
      dresp = '{data: 32'h20 + prev, resp: 2'b00};
      #1;
      if (k < 4) begin
        checks++; if (dv_o !== 1'b1 || dreq_o.addr !== 7'(7'h20 + g)) begin fails++; $display("FAIL contention_gnt k=%0d got=%h exp=%h", k, dreq_o.addr, 7'h20 + g); end
        checks++; if (rr_o !== 2'(1 << g)) begin fails++; $display("FAIL contention_ready k=%0d got=%b exp=%b", k, rr_o, 2'(1 << g)); end
      end
      if (k > 0) begin
        checks++; if (resp_v_o !== 2'(1 << prev) || resp_o[prev].data !== 32'(32'h20 + prev)) begin fails++; $display("FAIL contention_resp k=%0d got=%b/%h exp=%b/%h", k, resp_v_o, resp_o[prev].data, 2'(1 << prev), 32'h20 + prev); end
      end
      tick();
      prev = g;
    end
    drv = 0; #1;
    checks++; if (outs !== 2'd0) begin fails++; $display("FAIL contention_outs got=%0d exp=0", outs); end
  endtask

  task automatic test_full();
    do_reset();
    rv = 2'b01; tick(); tick(); #1;
    checks++; if (outs !== 2'd2) begin fails++; $display("FAIL full_outs got=%0d exp=2", outs); end
    checks++; if (dv_o !== 1'b0 || rr_o !== 2'b00) begin fails++; $display("FAIL full_stall got=%b/%b exp=0/00", dv_o, rr_o); end
    tick(); drv = 1; dresp = '{data: 32'h1, resp: 2'b00}; #1;
    checks++; if (dv_o !== 1'b0 || resp_v_o !== 2'b01) begin fails++; $display("FAIL full_pop_cycle got=%b/%b exp=0/01", dv_o, resp_v_o); end
    tick(); drv = 0; #1;
    checks++; if (dv_o !== 1'b1 || rr_o !== 2'b01) begin fails++; $display("FAIL full_regrant got=%b/%b exp=1/01", dv_o, rr_o); end
    tick(); rv = 0; #1;
    checks++; if (outs !== 2'd2) begin fails++; $display("FAIL full_refill got=%0d exp=2", outs); end
    drv = 1; tick(); tick(); drv = 0; #1;
    checks++; if (outs !== 2'd0) begin fails++; $display("FAIL full_drain got=%0d exp=0", outs); end
  endtask

  task automatic test_backpressure();
    do_reset();
    rv = 2'b10; #1;
    checks++; if (rr_o !== 2'b10) begin fails++; $display("FAIL bp_first got=%b exp=10", rr_o); end
    tick(); rv = 2'b01; #1;
    checks++; if (rr_o !== 2'b01) begin fails++; $display("FAIL bp_second got=%b exp=01", rr_o); end
    tick(); rv = 0; drv = 1; resp_rdy = 2'b01; dresp = '{data: 32'hAB, resp: 2'b00};
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (drr_o !== 1'b0 || resp_v_o !== 2'b10 || outs !== 2'd2) begin fails++; $display("FAIL bp_hold c=%0d got=%b/%b/%0d exp=0/10/2", c, drr_o, resp_v_o, outs); end
      tick();
    end
    resp_rdy = 2'b11; #1;
    checks++; if (drr_o !== 1'b1 || resp_v_o !== 2'b10) begin fails++; $display("FAIL bp_release got=%b/%b exp=1/10", drr_o, resp_v_o); end
    tick(); #1;
    checks++; if (resp_v_o !== 2'b01) begin fails++; $display("FAIL bp_next got=%b exp=01", resp_v_o); end
    tick(); drv = 0; #1;
    checks++; if (outs !== 2'd0) begin fails++; $display("FAIL bp_outs got=%0d exp=0", outs); end
  endtask

  task automatic test_unexp_clear();
    drv = 1; #1;
    checks++; if (unexp !== 1'b1 || drr_o !== 1'b1 || resp_v_o !== 2'b00) begin fails++; $display("FAIL unexp_pulse got=%b/%b/%b exp=1/1/00", unexp, drr_o, resp_v_o); end
    tick(); drv = 0; #1;
    checks++; if (unexp !== 1'b0) begin fails++; $display("FAIL unexp_end got=%b exp=0", unexp); end
    rv = 2'b01; tick(); tick(); #1;
    checks++; if (outs !== 2'd2) begin fails++; $display("FAIL clear_pre got=%0d exp=2", outs); end
    clr = 1; rv = 2'b11; drv = 1; #1;
    checks++; if (dv_o !== 1'b0 || resp_v_o !== 2'b00 || drr_o !== 1'b1 || unexp !== 1'b0) begin fails++; $display("FAIL clear_cycle got=%b/%b/%b/%b exp=0/00/1/0", dv_o, resp_v_o, drr_o, unexp); end
    tick(); clr = 0; drv = 0; #1;
    checks++; if (outs !== 2'd0) begin fails++; $display("FAIL clear_outs got=%0d exp=0", outs); end
    checks++; if (rr_o !== 2'b01) begin fails++; $display("FAIL clear_ptr got=%b exp=01", rr_o); end
    tick(); rv = 0; drv = 1; tick(); drv = 0; #1;
    checks++; if (outs !== 2'd0) begin fails++; $display("FAIL clear_drain got=%0d exp=0", outs); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_full();
    test_backpressure();
    test_unexp_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/dm_dmi_arb.md
Name: dm_dmi_arb

Overview:
- Shares the single DMI request/response port of the debug module's CSR block between NrInit DMI initiators, e.g. a JTAG DTM plus a SoC-side debug mailbox.
- Arbitrates requests round-robin and records the initiator ID of every accepted request in an in-order routing FIFO.
- Steers each returning response back to the initiator that issued it.
- Sits between the DTM(s) and the DM top-level DMI port.

Parameters:
- NrInit, 2, number of DMI initiators (≥1).
- MaxOutstanding, 2, routing-FIFO depth = max accepted-but-unanswered requests (≥1).
- IdW, (NrInit>1 ? $clog2(NrInit) : 1), localparam, initiator ID width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- clear_i  in  1  synchronous flush of arbiter state (driven from DTM dmi reset)
- init_req_valid_i  in  NrInit  per-initiator request valid
- init_req_ready_o  out  NrInit  per-initiator request ready
- init_req_i  in  NrInit x dm::dmi_req_t (41b)  per-initiator request {addr[6:0], op[1:0], data[31:0]}
- init_resp_valid_o  out  NrInit  per-initiator response valid
- init_resp_ready_i  in  NrInit  per-initiator response ready
- init_resp_o  out  NrInit x dm::dmi_resp_t (34b)  per-initiator response; all lanes carry the same data
- dmi_req_valid_o  out  1  downstream request valid
- dmi_req_ready_i  in  1  downstream request ready
- dmi_req_o  out  dm::dmi_req_t  downstream request
- dmi_resp_valid_i  in  1  downstream response valid
- dmi_resp_ready_o  out  1  downstream response ready
- dmi_resp_i  in  dm::dmi_resp_t  downstream response
- unexp_resp_o  out  1  1-cycle pulse: response arrived with FIFO empty
- outstanding_o  out  $clog2(MaxOutstanding+1)  current routing-FIFO fill count

Behaviour:
- Reset (rst_i=1 at clock edge):
  - FIFO empty, count 0; RR pointer 0.
  - unexp_resp_o=0.
  - All valid/ready outputs 0 as long as no request valid is presented.
- Grant:
  - Round-robin priority starting at the RR pointer, searching upward with wrap.
  - Grant is combinational from init_req_valid_i; granted ID = first valid at or after the pointer.
  - Grant is suppressed when the FIFO is full, or when clear_i=1.
- Request path:
  - dmi_req_valid_o = any grant.
  - dmi_req_o = init_req_i[gnt]; zero when no grant.
  - init_req_ready_o[gnt] = dmi_req_ready_i; all other ready bits 0.
  - Zero added latency, fully combinational forward path.
- On request handshake (dmi_req_valid_o & dmi_req_ready_i):
  - Push gnt ID into the FIFO.
  - RR pointer <= gnt+1, wrapping to 0 at NrInit.
- A valid request that is not accepted keeps its grant. The pointer moves only on handshake, so no grant switching occurs mid-handshake.
- Response path:
  - head = FIFO head ID.
  - If FIFO non-empty: init_resp_valid_o[head] = dmi_resp_valid_i; dmi_resp_ready_o = init_resp_ready_i[head]; other valids 0.
  - Pop on dmi_resp_valid_i & dmi_resp_ready_o.
- Downstream returns responses in request order; the FIFO depends on it.
- Unexpected response (FIFO empty with dmi_resp_valid_i=1):
  - dmi_resp_ready_o=1, response dropped.
  - unexp_resp_o=1 for that cycle; no initiator valid asserted.
- FIFO boundaries:
  - Push and pop in the same cycle: count unchanged, read/write pointers both advance, wrap modulo MaxOutstanding.
  - Full: no grant issued; pop still allowed; a request may be granted in the cycle after the pop (not the same cycle).
  - Empty: push and pop cannot coincide, since the response check uses the pre-push state.
- clear_i:
  - Next cycle: FIFO empty, RR pointer 0.
  - During the clear cycle: no grants and no response routing. dmi_resp_ready_o=1 drains any response without flagging it.
- clear_i and rst_i together: reset wins; result is identical.

Optional Feature:
- Macro: DM_DMI_ARB_LOCK_EN.
- Enabled:
  - Adds input port init_lock_i[NrInit].
  - While the initiator that last completed a handshake holds its lock bit high, only that initiator is granted; the pointer is frozen on it.
  - Others see ready=0.
  - Lock is released when the bit drops; round-robin resumes from owner+1.
  - Lock is ignored for an initiator with no valid request for 16 consecutive cycles (4-bit watchdog counter), which prevents starvation.
  - clear_i and reset release the lock.
- Disabled: port absent; pure round-robin.

Decomposition:
- Shared package dm (existing): dmi_req_t, dmi_resp_t, dtm_op_e.
- New package entries: DmiArbMaxInit constant = 8; lock watchdog limit constant = 16.
- One sub-module: dm_dmi_arb_fifo, an ID FIFO of parameter width and depth with full/empty/count outputs and synchronous clear.

Test Plan:
- Single request: init0 reads addr 0x11; downstream ready; response data 0x0000_0C82 -> init_resp_valid_o=2'b01 carrying 0x0000_0C82; outstanding_o goes 1 then 0.
- Contention: both valid every cycle, ready=1, MaxOutstanding=2 with immediate responses -> grants alternate 0,1,0,1; each initiator gets its own addr echo back.
- Full: hold dmi_resp_valid_i=0, issue 3 requests -> third stalls (ready=0, outstanding_o=2); one response pops -> third granted the next cycle.
- Backpressure ordering: accept init1 then init0; init1 resp_ready=0 for 5 cycles -> dmi_resp_ready_o=0 and init0 receives nothing until init1 takes its response.
- Unexpected response and clear: resp_valid with FIFO empty -> unexp_resp_o one-cycle pulse; clear_i with 2 outstanding -> outstanding_o=0 next cycle, RR pointer 0.
- With DM_DMI_ARB_LOCK_EN: init1 locks after a handshake, init0 requests continuously -> init0 blocked until lock drops or 16 idle cycles of init1, then granted.
